rvv_backend_retire_vd_merge: RTL

- Sits directly downstream of dispatch byte-type generation, on the retire side.
- Collects PU results for one destination vector register across one or more uops, e.g. the 2 or 4 uops of a narrowing instruction, which share one vd.
- Merges collected bytes with old vd data using the per-byte BYTE_TYPE_t and vta/vma policy.
- Emits one fully-formed vd write to the VRF write port.

---
 rtl/rvv_backend_retire_vd_merge_pkg.sv | 19 +
 rtl/rvv_backend_retire_vd_merge_if.sv | 35 +++
 rtl/rvv_backend_retire_byte_merge.sv | 28 ++
 rtl/rvv_backend_retire_vd_merge.sv | 117 +++++++++++
 4 files changed

// File: rtl/rvv_backend_retire_vd_merge_pkg.sv
// Shared types for the retire-side vd merge block: per-byte type encoding and merge FSM states.
package rvv_backend_retire_vd_merge_pkg;

  localparam int unsigned VLENB = 16;

  typedef enum logic [1:0] {
    TAIL          = 2'd0,
    NOT_CHANGE    = 2'd1,
    BODY_INACTIVE = 2'd2,
    BODY_ACTIVE   = 2'd3
  } BYTE_TYPE_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } MERGE_STATE_e;

endpackage

// File: rtl/rvv_backend_retire_vd_merge_if.sv
// Uop request and VRF write-back bundle for the vd merge block.
interface rvv_backend_retire_vd_merge_if #(
  parameter int unsigned VLENB           = rvv_backend_retire_vd_merge_pkg::VLENB,
  parameter int unsigned UOP_INDEX_WIDTH = 3
);
  logic                       uop_valid;
  logic                       uop_ready;
  logic [4:0]                 uop_vd_addr;
  logic [UOP_INDEX_WIDTH-1:0] uop_index;
  logic                       uop_last;
  logic [VLENB*8-1:0]         uop_res_data;
  logic [VLENB-1:0]           uop_res_strobe;
  logic [VLENB*2-1:0]         uop_vd_type;
  logic [VLENB*8-1:0]         uop_old_data;
  logic                       uop_vta;
  logic                       uop_vma;
  logic                       wb_valid;
  logic                       wb_ready;
  logic [4:0]                 wb_vd_addr;
  logic [VLENB*8-1:0]         wb_data;
  logic [VLENB-1:0]           wb_strobe;
  logic                       merge_err;

  modport master (
    output uop_valid, uop_vd_addr, uop_index, uop_last, uop_res_data, uop_res_strobe,
           uop_vd_type, uop_old_data, uop_vta, uop_vma, wb_ready,
    input  uop_ready, wb_valid, wb_vd_addr, wb_data, wb_strobe, merge_err
  );

  modport slave (
    input  uop_valid, uop_vd_addr, uop_index, uop_last, uop_res_data, uop_res_strobe,
           uop_vd_type, uop_old_data, uop_vta, uop_vma, wb_ready,
    output uop_ready, wb_valid, wb_vd_addr, wb_data, wb_strobe, merge_err
  );
endinterface

// File: rtl/rvv_backend_retire_byte_merge.sv
// Per-byte commit select: collected result, old vd byte or agnostic fill, plus write strobe.
module rvv_backend_retire_byte_merge
  import rvv_backend_retire_vd_merge_pkg::*;
(
  input  logic       written,
  input  logic [7:0] acc_byte,
  input  logic [7:0] old_byte,
  input  BYTE_TYPE_t byte_type,
  input  logic       vta,
  input  logic       vma,
  output logic [7:0] data,
  output logic       strobe
);

  // Tail and not-change bytes never take the collected result, whatever the strobe said.
  always_comb begin
    data   = old_byte;
    strobe = 1'b1;
    case (byte_type)
      BODY_ACTIVE:   data = written ? acc_byte : old_byte;
      BODY_INACTIVE: data = written ? acc_byte : (vma ? 8'hFF : old_byte);
      TAIL:          data = vta ? 8'hFF : old_byte;
      NOT_CHANGE:    strobe = 1'b0;
      default:       data = old_byte;
    endcase
  end

endmodule

// File: rtl/rvv_backend_retire_vd_merge.sv
// Collects uop results for one vd and emits a single merged VRF write.
// Optional: RVV_VD_MERGE_BACK2BACK_EN lets a new uop be accepted in the cycle the write drains.
module rvv_backend_retire_vd_merge
  import rvv_backend_retire_vd_merge_pkg::*;
#(
  parameter int unsigned VLENB           = 16,
  parameter int unsigned UOP_INDEX_WIDTH = 3,
  parameter int unsigned MAX_UOPS_PER_VD = 4
) (
  input logic                           clk,
  input logic                           rst,
  rvv_backend_retire_vd_merge_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_UOPS_PER_VD + 1);

  MERGE_STATE_e       state, state_nxt;
  logic [4:0]         vd_addr_q;
  logic [VLENB*8-1:0] acc;
  logic [VLENB-1:0]   wr_mask;
  logic [CNT_W-1:0]   uop_cnt;
  logic [4:0]         wb_vd_addr_q;
  logic [VLENB*8-1:0] wb_data_q;
  logic [VLENB-1:0]   wb_strobe_q;
  logic               merge_err_q;

  logic               accept, grp_open, addr_mismatch, overflow, commit;
  logic [VLENB*8-1:0] acc_merged, data_merged;
  logic [VLENB-1:0]   mask_merged, strobe_merged;
  logic               unused_index;

  assign unused_index  = ^bus.uop_index;
  assign accept        = bus.uop_valid & bus.uop_ready;
  assign grp_open      = (state == ACCUM);
  assign addr_mismatch = grp_open & (bus.uop_vd_addr != vd_addr_q);
  assign overflow      = grp_open & (uop_cnt == CNT_W'(MAX_UOPS_PER_VD)) & ~bus.uop_last;
  assign commit        = accept & (bus.uop_last | overflow);

  always_comb begin
    acc_merged  = acc;
    mask_merged = (grp_open ? wr_mask : '0) | bus.uop_res_strobe;
    for (int unsigned b = 0; b < VLENB; b++) begin
      if (bus.uop_res_strobe[b]) acc_merged[b*8 +: 8] = bus.uop_res_data[b*8 +: 8];
    end
  end

  for (genvar b = 0; b < VLENB; b++) begin : g_byte
    rvv_backend_retire_byte_merge u_byte (
      .written   (mask_merged[b]),
      .acc_byte  (acc_merged[b*8 +: 8]),
      .old_byte  (bus.uop_old_data[b*8 +: 8]),
      .byte_type (BYTE_TYPE_t'(bus.uop_vd_type[b*2 +: 2])),
      .vta       (bus.uop_vta),
      .vma       (bus.uop_vma),
      .data      (data_merged[b*8 +: 8]),
      .strobe    (strobe_merged[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A drain with a simultaneous accept starts the new group straight from OUT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = commit ? OUT : ACCUM;
      OUT:         if (bus.wb_ready) state_nxt = accept ? (commit ? OUT : ACCUM) : IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef RVV_VD_MERGE_BACK2BACK_EN
    bus.uop_ready = (state != OUT) | bus.wb_ready;
`else
    bus.uop_ready = (state != OUT);
`endif
    bus.wb_valid  = (state == OUT);
  end

  // Group bookkeeping is cleared at commit; it is ignored outside ACCUM, so this matches clearing on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      vd_addr_q    <= '0;
      acc          <= '0;
      wr_mask      <= '0;
      uop_cnt      <= '0;
      wb_vd_addr_q <= '0;
      wb_data_q    <= '0;
      wb_strobe_q  <= '0;
      merge_err_q  <= 1'b0;
    end else begin
      if (commit) begin
        wr_mask      <= '0;
        uop_cnt      <= '0;
        wb_vd_addr_q <= grp_open ? vd_addr_q : bus.uop_vd_addr;
        wb_data_q    <= data_merged;
        wb_strobe_q  <= strobe_merged;
      end else if (accept) begin
        acc     <= acc_merged;
        wr_mask <= mask_merged;
        uop_cnt <= grp_open ? uop_cnt + CNT_W'(1) : CNT_W'(1);
        if (!grp_open) vd_addr_q <= bus.uop_vd_addr;
      end
      if (accept && (addr_mismatch || overflow)) merge_err_q <= 1'b1;
    end
  end

  assign bus.wb_vd_addr = wb_vd_addr_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_strobe  = wb_strobe_q;
  assign bus.merge_err  = merge_err_q;

endmodule
